// File: rtl/instr_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC and issues one req/ack fetch at a time. When decode stalls
// after a word has been acked, a one-entry buffer parks that word so the
// fetch is not lost. A redirect flushes everything and restarts at a new PC.
module instr_fetch #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [15:0]       id_instr,
  output logic [4:0]        id_opcode,
  output logic [10:0]       id_imm11
);

  // BOOT: one idle cycle after reset; REQ: fetch outstanding;
  // WAIT: acked word parked in the buffer until decode accepts it.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              id_valid_nxt;
  logic [ADDR_W-1:0] id_pc_nxt;
  logic [15:0]       id_instr_nxt;
  logic [ADDR_W-1:0] buf_pc, buf_pc_nxt;
  logic [15:0]       buf_instr, buf_instr_nxt;

  // Register all fetch state; reset takes effect immediately, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_instr  <= '0;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      id_valid  <= id_valid_nxt;
      id_pc     <= id_pc_nxt;
      id_instr  <= id_instr_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_instr <= buf_instr_nxt;
    end
  end

  // Next-state and datapath decisions; redirect outranks ack and stall.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_nxt     = state;
    pc_nxt        = pc;
    id_valid_nxt  = id_valid;
    id_pc_nxt     = id_pc;
    id_instr_nxt  = id_instr;
    buf_pc_nxt    = buf_pc;
    buf_instr_nxt = buf_instr;

    unique case (state)
      BOOT: begin
        state_nxt = REQ;
      end

      REQ: begin
        if (redirect) begin
          // Any ack arriving this cycle belongs to the flushed path.
          pc_nxt       = redirect_pc;
          id_valid_nxt = 1'b0;
        end else if (imem_ack) begin
          pc_nxt = pc + ADDR_W'(1);
          if (!stall) begin
            id_instr_nxt = imem_rdata;
            id_pc_nxt    = pc;
            id_valid_nxt = 1'b1;
          end else begin
            buf_instr_nxt = imem_rdata;
            buf_pc_nxt    = pc;
            state_nxt     = WAIT;
          end
        end else if (!stall) begin
          // Decode consumed the held word and nothing new arrived: bubble.
          id_valid_nxt = 1'b0;
        end
      end

      WAIT: begin
        // Acks here are protocol errors and are ignored.
        if (redirect) begin
          pc_nxt       = redirect_pc;
          id_valid_nxt = 1'b0;
          state_nxt    = REQ;
        end else if (!stall) begin
          id_instr_nxt = buf_instr;
          id_pc_nxt    = buf_pc;
          id_valid_nxt = 1'b1;
          state_nxt    = REQ;
        end
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign id_opcode = id_instr[15:11];
  assign id_imm11  = id_instr[10:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a transaction-level model (queue of
// fetched-but-undelivered words) is compared every cycle, and directed
// scenarios pin reset, stall, redirect, PC wrap, async reset and ack latency.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [15:0] id_instr;
  logic [4:0]  id_opcode;
  logic [10:0] id_imm11;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_opcode  (id_opcode),
    .id_imm11   (id_imm11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  // Acks after 'lat' request cycles with word = addr ^ 16'hA500.
  // 'spurious' injects an ack while no request is outstanding.
  int lat      = 1;
  int cnt      = 0;
  bit spurious = 1'b0;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req && !rst) begin
        if (cnt + 1 >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ 16'hA500;
          cnt        = 0;
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end else begin
        imem_ack   = spurious;
        imem_rdata = 16'hDEAD;
        cnt        = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Words fetched but not yet handed to decode sit in 'pend'; a new fetch is
  // only issued while 'pend' is empty. Each non-stalled cycle decode takes
  // the oldest pending word, or sees a bubble if there is none.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetched_t;

  fetched_t    pend[$];
  bit          m_live     = 1'b0;
  logic [15:0] m_pc       = 16'h0000;
  bit          m_valid    = 1'b0;
  logic [15:0] m_id_pc    = 16'h0000;
  logic [15:0] m_id_instr = 16'h0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_live     = 1'b0;
      m_pc       = 16'h0000;
      m_valid    = 1'b0;
      m_id_pc    = 16'h0000;
      m_id_instr = 16'h0000;
      pend.delete();
    end else if (!m_live) begin
      m_live = 1'b1;
    end else if (redirect) begin
      m_pc    = redirect_pc;
      m_valid = 1'b0;
      pend.delete();
    end else begin
      fetched_t f;
      if (pend.size() == 0 && imem_ack) begin
        f.pc    = m_pc;
        f.instr = imem_rdata;
        pend.push_back(f);
        m_pc = m_pc + 16'd1;
      end
      if (!stall) begin
        if (pend.size() > 0) begin
          f          = pend.pop_front();
          m_id_pc    = f.pc;
          m_id_instr = f.instr;
          m_valid    = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare every output against the model once per cycle, mid-period.
  initial begin
    forever begin
      @(negedge clk);
      check("m_req",    {31'b0, imem_req}, {31'b0, (m_live && pend.size() == 0)});
      check("m_addr",   {16'b0, imem_addr}, {16'b0, m_pc});
      check("m_valid",  {31'b0, id_valid}, {31'b0, m_valid});
      check("m_id_pc",  {16'b0, id_pc}, {16'b0, m_id_pc});
      check("m_instr",  {16'b0, id_instr}, {16'b0, m_id_instr});
      check("m_opcode", {27'b0, id_opcode}, {27'b0, m_id_instr[15:11]});
      check("m_imm11",  {21'b0, id_imm11}, {21'b0, m_id_instr[10:0]});
    end
  end

  // ---------------- directed scenarios ----------------
  logic [15:0] p;

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_addr",  {16'b0, imem_addr}, 32'h0000);
    check("rst_instr", {16'b0, id_instr}, 32'h0000);
    rst = 1'b0;

    // Free run, single-cycle ack: BOOT, then first valid on the 2nd edge.
    @(negedge clk);
    check("boot_valid", {31'b0, id_valid}, 32'd0);
    check("boot_req",   {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    check("first_valid", {31'b0, id_valid}, 32'd1);
    check("first_pc",    {16'b0, id_pc}, 32'h0000);
    check("first_instr", {16'b0, id_instr}, 32'hA500);
    @(negedge clk);
    check("second_pc",    {16'b0, id_pc}, 32'h0001);
    check("second_instr", {16'b0, id_instr}, 32'hA501);
    check("second_opc",   {27'b0, id_opcode}, 32'h14);
    check("second_imm",   {21'b0, id_imm11}, 32'h501);
    repeat (4) @(negedge clk);
    check("run_pc", {16'b0, id_pc}, 32'h0005);

    // Stall for three cycles while an ack arrives; spurious ack in WAIT.
    p     = id_pc;
    stall = 1'b1;
    @(negedge clk);
    check("stall_req0",  {31'b0, imem_req}, 32'd0);
    check("stall_hold0", {16'b0, id_pc}, {16'b0, p});
    check("stall_val0",  {31'b0, id_valid}, 32'd1);
    spurious = 1'b1;
    @(negedge clk);
    spurious = 1'b0;
    check("stall_req1",  {31'b0, imem_req}, 32'd0);
    check("stall_hold1", {16'b0, id_pc}, {16'b0, p});
    @(negedge clk);
    check("stall_hold2", {16'b0, id_pc}, {16'b0, p});
    check("stall_addr",  {16'b0, imem_addr}, {16'b0, p + 16'd2});
    stall = 1'b0;
    @(negedge clk);
    check("unstall_pc",  {16'b0, id_pc}, {16'b0, p + 16'd1});
    check("unstall_val", {31'b0, id_valid}, 32'd1);
    check("unstall_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    check("after_pc", {16'b0, id_pc}, {16'b0, p + 16'd2});

    // Redirect in the same cycle as an ack.
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    check("redir_valid", {31'b0, id_valid}, 32'd0);
    check("redir_addr",  {16'b0, imem_addr}, 32'h0040);
    @(negedge clk);
    check("redir_pc",    {16'b0, id_pc}, 32'h0040);
    check("redir_instr", {16'b0, id_instr}, 32'hA540);
    check("redir_val1",  {31'b0, id_valid}, 32'd1);

    // PC wrap at 16'hFFFF.
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0;
    check("wrap_addr0", {16'b0, imem_addr}, 32'hFFFF);
    @(negedge clk);
    check("wrap_pc",    {16'b0, id_pc}, 32'hFFFF);
    check("wrap_instr", {16'b0, id_instr}, 32'h5AFF);
    check("wrap_addr1", {16'b0, imem_addr}, 32'h0000);

    // Two-cycle ack latency: stable address, bubbles between instructions.
    lat = 2;
    @(negedge clk);
    check("lat_bub0",  {31'b0, id_valid}, 32'd0);
    check("lat_req0",  {31'b0, imem_req}, 32'd1);
    check("lat_addr0", {16'b0, imem_addr}, 32'h0000);
    @(negedge clk);
    check("lat_val0",  {31'b0, id_valid}, 32'd1);
    check("lat_pc0",   {16'b0, id_pc}, 32'h0000);
    check("lat_addr1", {16'b0, imem_addr}, 32'h0001);
    @(negedge clk);
    check("lat_bub1",  {31'b0, id_valid}, 32'd0);
    check("lat_addr2", {16'b0, imem_addr}, 32'h0001);
    @(negedge clk);
    check("lat_val1",  {31'b0, id_valid}, 32'd1);
    check("lat_pc1",   {16'b0, id_pc}, 32'h0001);

    // Enter WAIT, then assert reset between clock edges.
    lat   = 1;
    stall = 1'b1;
    @(negedge clk);
    check("wait_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, id_valid}, 32'd0);
    check("arst_req",   {31'b0, imem_req}, 32'd0);
    check("arst_addr",  {16'b0, imem_addr}, 32'h0000);
    check("arst_pc",    {16'b0, id_pc}, 32'h0000);
    check("arst_instr", {16'b0, id_instr}, 32'h0000);
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_boot_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    check("rel_req",  {31'b0, imem_req}, 32'd1);
    check("rel_addr", {16'b0, imem_addr}, 32'h0000);
    @(negedge clk);
    check("rel_valid", {31'b0, id_valid}, 32'd1);
    check("rel_pc",    {16'b0, id_pc}, 32'h0000);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
